// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO library
package fifo_pkg;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_BURST,
        BR_DRAIN
    } burstState_e;

    function automatic int fill_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_connect.sv
// rtl/fifo_connect.sv - FIFO link bundle: write side, read side and fill status
interface fifoConnect
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) ();

    localparam int FILLBITS = fill_bits(DEPTH);

    typedef struct packed {
        logic                valid;
        logic [FILLBITS-1:0] fillLevel;
    } fill_status_t;

    logic             write;
    logic [WIDTH-1:0] datain;
    logic             read;
    logic [WIDTH-1:0] dataout;
    fill_status_t     fillStatus;

    modport reader (
        output read,
        output write,
        output datain,
        input  dataout,
        input  fillStatus
    );

endinterface

// File: rtl/stream_skid2.sv
// rtl/stream_skid2.sv - two-entry in-order stream buffer with occupancy output
module stream_skid2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       occ
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } word_t;

    word_t      ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0] occ_q, occ_d;
    logic       pop, push;
    word_t      in_word;

    assign in_word = '{data: in_data, last: in_last};
    assign pop     = (occ_q != 2'd0) && out_ready;
    // A push into a full buffer is only honoured when the head leaves in the same cycle
    assign push    = in_valid && ((occ_q != 2'd2) || pop);

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = in_word;
                else               ent1_d = in_word;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = in_word;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = ent0_q.data;
    assign out_last  = ent0_q.last;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - waits for a full or flushed burst, pops it and streams it out
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int  WIDTH     = 32,
    parameter int  DEPTH     = 32,
    parameter int  BURST_LEN = 8,
    localparam int FILLBITS  = fill_bits(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    fifoConnect.reader          link,
    input  logic                flush,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic                busy,
    output logic [FILLBITS-1:0] burst_len_cur
);

    localparam logic [FILLBITS-1:0] BURST_LEN_F = FILLBITS'(BURST_LEN);
    localparam logic [FILLBITS-1:0] ONE_F       = FILLBITS'(1);

    burstState_e         state_q, state_d;
    logic [FILLBITS-1:0] len_q, len_d;
    logic [FILLBITS-1:0] rem_q, rem_d;
    logic                pop;
    logic [1:0]          skid_occ;
    logic [FILLBITS-1:0] fill;
    logic                fvalid;

    assign fill   = link.fillStatus.fillLevel;
    assign fvalid = link.fillStatus.valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        unique case (state_q)
            BR_IDLE: begin
                if (fill >= BURST_LEN_F) begin
                    len_d   = BURST_LEN_F;
                    rem_d   = BURST_LEN_F;
                    state_d = BR_BURST;
                end else if (flush && fvalid) begin
                    len_d   = fill;
                    rem_d   = fill;
                    state_d = BR_BURST;
                end
            end
            BR_BURST: begin
                // An underrunning FIFO simply stalls here until more data shows up
                pop = fvalid && (rem_q != '0) &&
                      ((skid_occ != 2'd2) || (m_valid && m_ready));
                if (pop) begin
                    rem_d = rem_q - ONE_F;
                    if (rem_q == ONE_F) state_d = BR_DRAIN;
                end
            end
            BR_DRAIN: begin
                if (m_valid && m_ready && m_last) begin
                    state_d = BR_IDLE;
                    len_d   = '0;
                end
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BR_IDLE;
            len_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

    stream_skid2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (pop),
        .in_data  (link.dataout),
        .in_last  (rem_q == ONE_F),
        .out_valid(m_valid),
        .out_data (m_data),
        .out_last (m_last),
        .out_ready(m_ready),
        .occ      (skid_occ)
    );

    assign link.read     = pop;
    assign link.write    = 1'b0;
    assign link.datain   = '0;
    assign busy          = (state_q != BR_IDLE);
    assign burst_len_cur = len_q;

endmodule
